lsu_read_path: RTL and testbench

Load-side counterpart of the LSU store address decoder. It accepts LSU read requests and decodes the address into the SRAM window, the output-buffer readback window or the input-buffer window. It sequences the SRAM read with a fixed latency, aligns and sign-extends the selected byte, halfword or word, and returns one registered load response to the core.

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/load_align.sv | 39 +++
 rtl/lsu_read_path.sv | 125 ++++++++++++
 tb/tb_lsu_read_path.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU load path: funct3 codes, address window
// constants, state/region enums and small decode helpers.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] SRAM_MATCH = 3'b001;
  localparam logic [3:0] BUF_MATCH  = 4'h7;
  localparam logic [3:0] OBUF_MATCH = 4'h0;
  localparam logic [3:0] IBUF_MATCH = 4'h8;

  typedef enum logic [1:0] {IDLE, SR_WAIT, RESP} state_t;
  typedef enum logic [1:0] {R_SRAM, R_OBUF, R_IBUF, R_NONE} region_t;

  // Takes addr[15:8]; the upper half of the address is ignored.
  function automatic region_t decode_region(input logic [7:0] hi);
    region_t r;
    r = R_NONE;
    if (hi[7:5] == SRAM_MATCH) r = R_SRAM;
    else if (hi[7:4] == BUF_MATCH && hi[3:0] == OBUF_MATCH) r = R_OBUF;
    else if (hi[7:4] == BUF_MATCH && hi[3:0] == IBUF_MATCH) r = R_IBUF;
    return r;
  endfunction

  // Misaligned access or a funct3 that is not a load.
  function automatic logic load_bad(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic bad;
    case (funct3)
      F3_LB, F3_LBU: bad = 1'b0;
      F3_LH, F3_LHU: bad = addr_lo[0];
      F3_LW:         bad = (addr_lo != 2'b00);
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects and extends the byte/halfword/word of a load; flags accesses that
// cannot be aligned (misaligned or non-load funct3), returning zero for them.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic        misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    misalign = load_bad(funct3, addr_lo);
    data     = '0;
    if (!misalign) begin
      case (funct3)
        F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
        F3_LBU:  data = {24'h0, byte_sel};
        F3_LH:   data = {{16{half_sel[15]}}, half_sel};
        F3_LHU:  data = {16'h0, half_sel};
        F3_LW:   data = word;
        default: data = '0;
      endcase
    end
  end

endmodule

// File: rtl/lsu_read_path.sv
// LSU load path: decodes the request window, sequences fixed-latency SRAM
// reads and returns one registered, aligned load response per request.
//
// state   | meaning
// IDLE    | no request in flight, ready to accept
// SR_WAIT | SRAM read issued, waiting SRAM_LAT cycles for data
// RESP    | read word is valid this cycle; response registers at the edge
module lsu_read_path
  import lsu_pkg::*;
#(
  parameter int SRAM_LAT = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_lsu_addr,
  input  logic        i_lsu_rden,
  input  logic        i_lsu_wren,
  input  logic [2:0]  i_lsu_funct3,
  output logic        o_lsu_ready,
  output logic        o_sram_rd_en,
  output logic [10:0] o_sram_addr,
  input  logic [31:0] i_sram_rdata,
  output logic [5:0]  o_buf_addr,
  input  logic [31:0] i_obuf_rdata,
  input  logic [31:0] i_ibuf_rdata,
  output logic [31:0] o_ld_data,
  output logic        o_ld_valid,
  output logic        o_ld_err
);

  localparam logic [2:0] LAT = 3'(SRAM_LAT);

  state_t      state;
  region_t     region_q;
  region_t     region_in;
  logic [1:0]  lo_q;
  logic [2:0]  f3_q;
  logic [2:0]  cnt;
  logic        accept;
  logic        sram_go;
  logic [31:0] word_sel;
  logic [31:0] aligned;
  logic        align_bad;
  logic        resp_err;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^i_lsu_addr[31:16];

  assign o_lsu_ready = (state != SR_WAIT);
  assign accept      = i_lsu_rden & o_lsu_ready & ~i_lsu_wren;
  assign region_in   = decode_region(i_lsu_addr[15:8]);
  // Erroring SRAM requests skip the read and answer straight from RESP.
  assign sram_go     = (region_in == R_SRAM) & ~load_bad(i_lsu_funct3, i_lsu_addr[1:0]);

  always_comb begin
    word_sel = '0;
    case (region_q)
      R_SRAM:  word_sel = i_sram_rdata;
      R_OBUF:  word_sel = i_obuf_rdata;
      R_IBUF:  word_sel = i_ibuf_rdata;
      default: word_sel = '0;
    endcase
  end

  load_align u_align (
    .word     (word_sel),
    .addr_lo  (lo_q),
    .funct3   (f3_q),
    .data     (aligned),
    .misalign (align_bad)
  );

  assign resp_err = align_bad | (region_q == R_NONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      region_q     <= R_NONE;
      lo_q         <= '0;
      f3_q         <= '0;
      cnt          <= '0;
      o_sram_rd_en <= 1'b0;
      o_sram_addr  <= '0;
      o_buf_addr   <= '0;
      o_ld_data    <= '0;
      o_ld_valid   <= 1'b0;
      o_ld_err     <= 1'b0;
    end else begin
      o_sram_rd_en <= 1'b0;
      o_ld_valid   <= 1'b0;
      if (state == RESP) begin
        o_ld_valid <= 1'b1;
        o_ld_err   <= resp_err;
        o_ld_data  <= resp_err ? 32'h0 : aligned;
      end
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            region_q    <= region_in;
            lo_q        <= i_lsu_addr[1:0];
            f3_q        <= i_lsu_funct3;
            o_sram_addr <= i_lsu_addr[12:2];
            o_buf_addr  <= i_lsu_addr[7:2];
            if (sram_go) begin
              state        <= SR_WAIT;
              cnt          <= LAT;
              o_sram_rd_en <= 1'b1;
            end else begin
              state <= RESP;
            end
          end else begin
            state <= IDLE;
          end
        end
        SR_WAIT: begin
          cnt <= cnt - 3'd1;
          // Counter hits zero as data becomes valid; RESP registers it.
          if (cnt == 3'd1) state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_read_path.sv
// Scoreboard bench for lsu_read_path: directed cases plus random loads checked
// against a behavioural load model with modelled SRAM and buffer memories.
module tb_lsu_read_path;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_lsu_addr;
  logic        i_lsu_rden;
  logic        i_lsu_wren;
  logic [2:0]  i_lsu_funct3;
  logic        o_lsu_ready;
  logic        o_sram_rd_en;
  logic [10:0] o_sram_addr;
  logic [31:0] i_sram_rdata;
  logic [5:0]  o_buf_addr;
  logic [31:0] i_obuf_rdata;
  logic [31:0] i_ibuf_rdata;
  logic [31:0] o_ld_data;
  logic        o_ld_valid;
  logic        o_ld_err;

  logic [31:0] sram_mem [0:2047];
  logic [31:0] obuf_mem [0:63];
  logic [31:0] ibuf_mem [0:63];

  typedef struct { int due; logic err; logic [31:0] data; } exp_t;
  typedef struct { int cyc; logic [10:0] addr; } strobe_t;
  typedef struct { int due; logic [10:0] addr; } rd_t;

  exp_t    exp_q[$];
  strobe_t strobe_q[$];
  rd_t     rd_q[$];

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          free_cyc = 0;
  logic [31:0] last_data = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign i_obuf_rdata = obuf_mem[o_buf_addr];
  assign i_ibuf_rdata = ibuf_mem[o_buf_addr];

  lsu_read_path #(.SRAM_LAT(LAT)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_lsu_addr   (i_lsu_addr),
    .i_lsu_rden   (i_lsu_rden),
    .i_lsu_wren   (i_lsu_wren),
    .i_lsu_funct3 (i_lsu_funct3),
    .o_lsu_ready  (o_lsu_ready),
    .o_sram_rd_en (o_sram_rd_en),
    .o_sram_addr  (o_sram_addr),
    .i_sram_rdata (i_sram_rdata),
    .o_buf_addr   (o_buf_addr),
    .i_obuf_rdata (i_obuf_rdata),
    .i_ibuf_rdata (i_ibuf_rdata),
    .o_ld_data    (o_ld_data),
    .o_ld_valid   (o_ld_valid),
    .o_ld_err     (o_ld_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp_v, cyc);
    end
  endtask

  // Reference load: window, size, signedness and alignment from plain arithmetic.
  function automatic void model_load(input logic [31:0] a, input logic [2:0] f3,
                                     output logic err, output logic [31:0] d,
                                     output logic sram_go);
    logic [31:0] w, mask, v;
    int sz;
    bit sgn, mapped, legal, is_sram;
    w = '0; mapped = 1; is_sram = 0;
    if (a[15:13] == 3'b001) begin w = sram_mem[a[12:2]]; is_sram = 1; end
    else if (a[15:8] == 8'h70) w = obuf_mem[a[7:2]];
    else if (a[15:8] == 8'h78) w = ibuf_mem[a[7:2]];
    else mapped = 0;
    legal = 1; sgn = 0; sz = 4;
    case (f3)
      3'd0: begin sz = 1; sgn = 1; end
      3'd4: sz = 1;
      3'd1: begin sz = 2; sgn = 1; end
      3'd5: sz = 2;
      3'd2: sz = 4;
      default: legal = 0;
    endcase
    err = !mapped || !legal || ((int'(a[1:0]) % sz) != 0);
    sram_go = is_sram && !err;
    d = '0;
    if (!err) begin
      v = w >> (8 * int'(a[1:0]));
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
      v = v & mask;
      if (sgn && v[8 * sz - 1]) v = v | ~mask;
      d = v;
    end
  endfunction

  // SRAM model: data valid LAT cycles after the strobe cycle, garbage otherwise.
  always @(negedge clk) begin
    while (rd_q.size() > 0 && rd_q[0].due < cyc) void'(rd_q.pop_front());
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      i_sram_rdata = sram_mem[rd_q[0].addr];
      void'(rd_q.pop_front());
    end else begin
      i_sram_rdata = $urandom;
    end
    if (rst_n && o_sram_rd_en) rd_q.push_back('{cyc + LAT, o_sram_addr});
  end

  // Monitor: pops expectations when the DUT presents strobes or responses.
  always @(negedge clk) begin
    if (o_sram_rd_en) begin
      if (strobe_q.size() == 0) chk("unexpected_strobe", {31'h0, o_sram_rd_en}, 32'h0);
      else begin
        strobe_t s;
        s = strobe_q.pop_front();
        chk("strobe_cycle", cyc, s.cyc);
        chk("strobe_addr", {21'h0, o_sram_addr}, {21'h0, s.addr});
      end
    end else if (strobe_q.size() > 0 && strobe_q[0].cyc <= cyc) begin
      chk("missing_strobe", {31'h0, o_sram_rd_en}, 32'h1);
      void'(strobe_q.pop_front());
    end
    if (o_ld_valid) begin
      if (exp_q.size() == 0) chk("unexpected_valid", {31'h0, o_ld_valid}, 32'h0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("valid_cycle", cyc, e.due);
        chk("ld_err", {31'h0, o_ld_err}, {31'h0, e.err});
        chk("ld_data", o_ld_data, e.data);
        last_data = e.data;
      end
    end else begin
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        chk("missing_valid", {31'h0, o_ld_valid}, 32'h1);
        void'(exp_q.pop_front());
      end
      chk("hold_data", o_ld_data, last_data);
    end
  end

  // Called just after a falling edge; returns just after the next one.
  task automatic issue(input logic [31:0] addr, input logic [2:0] f3,
                       input logic wren, input logic rden);
    int c, e;
    logic err, go;
    logic [31:0] d;
    c = cyc;
    chk("ready", {31'h0, o_lsu_ready}, {31'h0, c >= free_cyc});
    i_lsu_addr = addr; i_lsu_funct3 = f3; i_lsu_rden = rden; i_lsu_wren = wren;
    @(posedge clk);
    e = c + 1;
    if (rden && !wren && c >= free_cyc) begin
      model_load(addr, f3, err, d, go);
      if (go) begin
        exp_q.push_back('{e + LAT + 1, err, d});
        strobe_q.push_back('{e, addr[12:2]});
        free_cyc = e + LAT;
      end else begin
        exp_q.push_back('{e + 1, err, d});
      end
    end
    @(negedge clk);
    i_lsu_rden = 1'b0; i_lsu_wren = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) issue($urandom, 3'($urandom_range(0, 7)), 1'b0, 1'b0);
  endtask

  task automatic check_reset_vals();
    chk("rst_ready", {31'h0, o_lsu_ready}, 32'h1);
    chk("rst_rd_en", {31'h0, o_sram_rd_en}, 32'h0);
    chk("rst_valid", {31'h0, o_ld_valid}, 32'h0);
    chk("rst_err", {31'h0, o_ld_err}, 32'h0);
    chk("rst_data", o_ld_data, 32'h0);
    chk("rst_sram_addr", {21'h0, o_sram_addr}, 32'h0);
    chk("rst_buf_addr", {26'h0, o_buf_addr}, 32'h0);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete(); strobe_q.delete();
    last_data = '0; free_cyc = 0;
    @(negedge clk);
    check_reset_vals();
    @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 2048; i++) sram_mem[i] = $urandom;
    for (int i = 0; i < 64; i++) begin obuf_mem[i] = $urandom; ibuf_mem[i] = $urandom; end
    sram_mem[1] = 32'hDEAD_BEEF;
    obuf_mem[0] = 32'h8011_2233;
    ibuf_mem[0] = 32'hA5A5_1234;
    i_lsu_addr = '0; i_lsu_rden = 1'b0; i_lsu_wren = 1'b0; i_lsu_funct3 = '0;
    i_sram_rdata = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;

    issue(32'h0000_2004, 3'b010, 1'b0, 1'b1);
    idle(4);
    issue(32'h0000_7003, 3'b000, 1'b0, 1'b1); idle(2);
    issue(32'h0000_7003, 3'b100, 1'b0, 1'b1); idle(2);
    issue(32'h0000_7802, 3'b101, 1'b0, 1'b1); idle(2);
    issue(32'h0000_7801, 3'b001, 1'b0, 1'b1); idle(2);
    issue(32'h0000_2002, 3'b010, 1'b0, 1'b1); idle(2);
    issue(32'h0000_2000, 3'b011, 1'b0, 1'b1); idle(2);
    issue(32'h0000_5000, 3'b010, 1'b0, 1'b1); idle(2);
    issue(32'h0000_7000, 3'b010, 1'b0, 1'b1);
    issue(32'h0000_7004, 3'b010, 1'b0, 1'b1); idle(3);
    issue(32'hFFFF_2004, 3'b010, 1'b0, 1'b1);
    issue(32'h0000_7000, 3'b010, 1'b0, 1'b1);
    issue(32'h0000_7004, 3'b010, 1'b0, 1'b1);
    issue(32'h0000_7803, 3'b000, 1'b0, 1'b1); idle(3);
    issue(32'h0000_2000, 3'b010, 1'b0, 1'b1);
    mid_reset();
    idle(4);
    issue(32'h0000_2000, 3'b010, 1'b0, 1'b1); idle(5);
    issue(32'h0000_2000, 3'b010, 1'b1, 1'b1); idle(3);

    for (int n = 0; n < 400; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: a[15:13] = 3'b001;
        1: a[15:8]  = 8'h70;
        2: a[15:8]  = 8'h78;
        default: ;
      endcase
      if ($urandom_range(0, 9) == 0) idle(1);
      else issue(a, 3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0), 1'b1);
    end

    for (int k = 0; k < 20; k++) if (exp_q.size() != 0 || strobe_q.size() != 0) idle(1);
    chk("drain_resp", exp_q.size(), 32'h0);
    chk("drain_strobe", strobe_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
